// File: rtl/count_display_seq_pkg.sv
// count_ctrl_pkg
//   Shared definitions for the count/display sequencer slice:
//   - state_t: sequencer FSM encoding (IDLE / START / WAIT)
//   - default widths for the binary count, the 4-digit BCD result and
//     the converter wait limit, so the sequencer and the blocks built
//     around it agree on the same numbers.
package count_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam int CNT_W_DEF   = 12;  // binary count width into the converter
  localparam int BCD_W_DEF   = 16;  // 4 BCD digits
  localparam int TIMEOUT_DEF = 64;  // WAIT cycles before giving up

endpackage : count_ctrl_pkg

// File: rtl/count_display_seq_if.sv
// count_display_seq_if
//   Bundle for the sequencer <-> count-to-BCD converter handshake.
//
//   Handshake: conv_start is a single-cycle request from the sequencer.
//   The converter later raises conv_rdy for at least one cycle with
//   conv_bcd valid in that same cycle. conv_rdy is a result-valid
//   strobe only; there is no back-pressure and the sequencer honours
//   it only while it is waiting for a result.
//
//   Signals:
//     conv_start : sequencer -> converter, start pulse
//     conv_rdy   : converter -> sequencer, result valid
//     conv_bcd   : converter -> sequencer, BCD result (BCD_W bits)
interface count_display_seq_if
  import count_ctrl_pkg::*;
#(
  parameter int BCD_W = BCD_W_DEF
);

  logic             conv_start;
  logic             conv_rdy;
  logic [BCD_W-1:0] conv_bcd;

  // Sequencer side
  modport master (
    output conv_start,
    input  conv_rdy,
    input  conv_bcd
  );

  // Converter side
  modport slave (
    input  conv_start,
    output conv_rdy,
    output conv_bcd
  );

endinterface : count_display_seq_if

// File: rtl/count_display_seq.sv
// count_display_seq
//   Control sequencer for a stopwatch-style count display. It turns the
//   run/pause and clear buttons plus the divider tick into counter
//   enable/clear pulses, requests a count-to-BCD conversion after every
//   counter change, and latches the converter result for the display.
//
//   Ports:
//     clk, reset  : system clock, synchronous active-high reset
//     run_tgl     : pulse, toggles run/pause
//     clr         : pulse, clears the counter and the error flag
//     tick        : pulse, divider enable
//     cnt_en      : counter increment enable (one cycle)
//     cnt_clr     : counter synchronous clear (one cycle)
//     conv_start  : converter start (one cycle)
//     conv_rdy    : converter result valid
//     conv_bcd    : converter result
//     disp_bcd    : latched value for the display driver
//     running     : run/pause state
//     busy        : FSM not in IDLE
//     err         : sticky conversion-timeout flag
//     dbg_state   : current FSM state, for observation
//
//   All outputs come straight from registers.
module count_display_seq
  import count_ctrl_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int BCD_W   = BCD_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_tgl,
  input  logic             clr,
  input  logic             tick,
  output logic             cnt_en,
  output logic             cnt_clr,
  output logic             conv_start,
  input  logic             conv_rdy,
  input  logic [BCD_W-1:0] conv_bcd,
  output logic [BCD_W-1:0] disp_bcd,
  output logic             running,
  output logic             busy,
  output logic             err,
  output state_t           dbg_state
);

  localparam int WC_W = $clog2(TIMEOUT + 1);

  // The sequencer never touches the binary count itself; CNT_W is kept
  // so the parameter set matches the counter/converter it sits beside.
  if (CNT_W < 1 || BCD_W < 4 || TIMEOUT < 1) begin : g_param_check
    $error("count_display_seq: CNT_W, BCD_W and TIMEOUT must be positive, BCD_W >= 4");
  end

  state_t           r_state;
  logic             r_running;
  logic             r_pending;
  logic             r_cnt_en;
  logic             r_cnt_clr;
  logic             r_conv_start;
  logic [BCD_W-1:0] r_disp_bcd;
  logic             r_busy;
  logic             r_err;
  logic [WC_W-1:0]  r_wait_cnt;

  logic             w_req_en;
  logic             w_req;
  logic [WC_W-1:0]  w_wait_nxt;
  logic             w_timeout;

  // clr beats tick when both arrive together.
  assign w_req_en   = tick & r_running & ~clr;
  assign w_req      = w_req_en | clr;
  assign w_wait_nxt = r_wait_cnt + 1'b1;
  // Fires on the TIMEOUT-th WAIT cycle without a result.
  assign w_timeout  = (w_wait_nxt == WC_W'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_running    <= 1'b0;
      r_pending    <= 1'b0;
      r_cnt_en     <= 1'b0;
      r_cnt_clr    <= 1'b0;
      r_conv_start <= 1'b0;
      r_disp_bcd   <= '0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
      r_wait_cnt   <= '0;
    end else begin
      r_cnt_en     <= w_req_en;
      r_cnt_clr    <= clr;
      r_conv_start <= 1'b0;

      if (run_tgl) r_running <= ~r_running;
      if (clr)     r_err     <= 1'b0;

      // The pending flag is set in the same edge that issues cnt_en /
      // cnt_clr, so IDLE can launch START on the very next edge while
      // the counter is already updating.
      r_pending <= r_pending | w_req;

      case (r_state)
        S_IDLE: begin
          if (r_pending) begin
            r_state      <= S_START;
            r_conv_start <= 1'b1;
            r_busy       <= 1'b1;
            // A request landing on this same edge survives the clear.
            r_pending    <= w_req;
          end
        end

        S_START: begin
          r_state    <= S_WAIT;
          r_wait_cnt <= '0;
        end

        S_WAIT: begin
          if (conv_rdy) begin
            // A result in the timeout cycle still counts as success.
            r_disp_bcd <= conv_bcd;
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
          end else if (w_timeout) begin
            r_err      <= 1'b1;
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_wait_cnt <= w_wait_nxt;
          end else begin
            r_wait_cnt <= w_wait_nxt;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign cnt_en     = r_cnt_en;
  assign cnt_clr    = r_cnt_clr;
  assign conv_start = r_conv_start;
  assign disp_bcd   = r_disp_bcd;
  assign running    = r_running;
  assign busy       = r_busy;
  assign err        = r_err;
  assign dbg_state  = r_state;

endmodule : count_display_seq

// File: tb/tb_count_display_seq.sv
module tb_count_display_seq;
  import count_ctrl_pkg::*;

  localparam int BCD_W = 16;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic             run_tgl;
  logic             clr;
  logic             tick;
  logic             cnt_en;
  logic             cnt_clr;
  logic [BCD_W-1:0] disp_bcd;
  logic             running;
  logic             busy;
  logic             err;
  state_t           dbg_state;

  count_display_seq_if #(.BCD_W(BCD_W)) cif ();

  count_display_seq #(
    .CNT_W   (12),
    .BCD_W   (BCD_W),
    .TIMEOUT (64)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run_tgl    (run_tgl),
    .clr        (clr),
    .tick       (tick),
    .cnt_en     (cnt_en),
    .cnt_clr    (cnt_clr),
    .conv_start (cif.conv_start),
    .conv_rdy   (cif.conv_rdy),
    .conv_bcd   (cif.conv_bcd),
    .disp_bcd   (disp_bcd),
    .running    (running),
    .busy       (busy),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_tests;
  int n_fail;
  logic [BCD_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulse counters observed away from the active edge.
  int n_start;
  int n_en;
  int n_clr;
  always @(negedge clk) begin
    if (!reset) begin
      if (cif.conv_start) n_start++;
      if (cnt_en)         n_en++;
      if (cnt_clr)        n_clr++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step(1);
    tick = 1'b0;
  endtask

  task automatic pulse_run();
    run_tgl = 1'b1;
    step(1);
    run_tgl = 1'b0;
  endtask

  task automatic wait_for_wait(input string tag);
    int budget;
    budget = 20;
    while (dbg_state != S_WAIT && budget > 0) begin
      step(1);
      budget--;
    end
    if (budget == 0) check({tag, "_reach_wait"}, 32'(dbg_state), 32'(S_WAIT));
  endtask

  // Deliver a result from the converter once the sequencer waits for it.
  task automatic finish_conv(input string tag, input logic [BCD_W-1:0] val);
    wait_for_wait(tag);
    cif.conv_rdy = 1'b1;
    cif.conv_bcd = val;
    step(1);
    cif.conv_rdy = 1'b0;
    cif.conv_bcd = '0;
    exp_q.push_back(val);
  endtask

  task automatic check_disp(input string tag);
    logic [BCD_W-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check(tag, 32'(disp_bcd), 32'(e));
    end
  endtask

  // ---------------- stimulus ----------------
  int s0;
  int e0;

  initial begin
    n_tests = 0; n_fail = 0;
    n_start = 0; n_en = 0; n_clr = 0;
    run_tgl = 1'b0; clr = 1'b0; tick = 1'b0;
    cif.conv_rdy = 1'b0; cif.conv_bcd = '0;
    reset = 1'b1;
    step(2);
    reset = 1'b0;

    // Reset state
    check("rst_running", 32'(running), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(err), 0);
    check("rst_disp", 32'(disp_bcd), 0);
    check("rst_cnt_en", 32'(cnt_en), 0);
    check("rst_cnt_clr", 32'(cnt_clr), 0);
    check("rst_conv_start", 32'(cif.conv_start), 0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));

    // Run, one tick, result 0001
    pulse_run();
    check("t1_running", 32'(running), 1);
    pulse_tick();
    check("t1_cnt_en_n1", 32'(cnt_en), 1);
    check("t1_start_n1", 32'(cif.conv_start), 0);
    step(1);
    check("t1_cnt_en_n2", 32'(cnt_en), 0);
    check("t1_start_n2", 32'(cif.conv_start), 1);
    check("t1_busy", 32'(busy), 1);
    step(2);
    cif.conv_rdy = 1'b1;
    cif.conv_bcd = 16'h0001;
    step(1);
    cif.conv_rdy = 1'b0;
    cif.conv_bcd = '0;
    exp_q.push_back(16'h0001);
    check_disp("t1_disp");
    check("t1_busy_done", 32'(busy), 0);
    check("t1_state_done", 32'(dbg_state), 32'(S_IDLE));
    // conv_rdy in IDLE is ignored
    cif.conv_rdy = 1'b1;
    cif.conv_bcd = 16'h9999;
    step(1);
    cif.conv_rdy = 1'b0;
    cif.conv_bcd = '0;
    check("t1_idle_rdy_ignored", 32'(disp_bcd), 32'h0001);

    // Paused: 5 ticks do nothing
    pulse_run();
    check("t2_running", 32'(running), 0);
    s0 = n_start; e0 = n_en;
    for (int i = 0; i < 5; i++) begin
      pulse_tick();
      step(1);
    end
    step(4);
    check("t2_no_cnt_en", 32'(n_en - e0), 0);
    check("t2_no_start", 32'(n_start - s0), 0);
    check("t2_disp_held", 32'(disp_bcd), 32'h0001);

    // clr and tick together while running
    pulse_run();
    check("t3_running", 32'(running), 1);
    s0 = n_start;
    clr = 1'b1; tick = 1'b1;
    step(1);
    clr = 1'b0; tick = 1'b0;
    check("t3_cnt_clr", 32'(cnt_clr), 1);
    check("t3_cnt_en", 32'(cnt_en), 0);
    finish_conv("t3", 16'h0000);
    check_disp("t3_disp");
    step(10);
    check("t3_one_conv", 32'(n_start - s0), 1);
    check("t3_idle", 32'(busy), 0);

    // 3 ticks during WAIT coalesce into one extra conversion
    s0 = n_start;
    pulse_tick();
    wait_for_wait("t4a");
    for (int i = 0; i < 3; i++) begin
      pulse_tick();
      step(1);
    end
    check("t4_still_wait", 32'(dbg_state), 32'(S_WAIT));
    finish_conv("t4a", 16'h0005);
    check_disp("t4_disp_a");
    finish_conv("t4b", 16'h0008);
    check_disp("t4_disp_b");
    step(10);
    check("t4_two_conv", 32'(n_start - s0), 2);
    check("t4_idle", 32'(dbg_state), 32'(S_IDLE));

    // Timeout: conv_rdy withheld
    pulse_tick();
    wait_for_wait("t5");
    step(63);
    check("t5_err_early", 32'(err), 0);
    check("t5_wait_early", 32'(dbg_state), 32'(S_WAIT));
    step(1);
    check("t5_err", 32'(err), 1);
    check("t5_state", 32'(dbg_state), 32'(S_IDLE));
    check("t5_disp_held", 32'(disp_bcd), 32'h0008);
    step(3);
    check("t5_err_sticky", 32'(err), 1);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check("t5_err_cleared", 32'(err), 0);
    check("t5_cnt_clr", 32'(cnt_clr), 1);
    finish_conv("t5", 16'h0000);
    check_disp("t5_disp_after_clr");

    // Reset in WAIT, late conv_rdy ignored
    step(2);
    pulse_tick();
    wait_for_wait("t6");
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    cif.conv_rdy = 1'b1;
    cif.conv_bcd = 16'h1234;
    step(1);
    cif.conv_rdy = 1'b0;
    cif.conv_bcd = '0;
    check("t6_disp", 32'(disp_bcd), 0);
    check("t6_state", 32'(dbg_state), 32'(S_IDLE));
    check("t6_busy", 32'(busy), 0);
    check("t6_running", 32'(running), 0);
    check("t6_err", 32'(err), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_count_display_seq
